l1_dcache: RTL and testbench

- Responder end of the CPU data-cache port: services load/store requests from the core's memory stage on a 128-bit line interface.
- 2-way set-associative, write-back, write-allocate L1 data cache, 16-byte lines, true-LRU per set.
- Sits between the core's dcache port and the next memory level (L2/arbiter) on a line-granular pmem interface.

---
 rtl/l1_dcache_pkg.sv | 31 +++
 rtl/l1_dcache_way.sv | 59 +++++
 rtl/l1_dcache.sv | 140 ++++++++++++++
 tb/tb_l1_dcache.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_dcache_pkg.sv
// Shared types for the L1 data cache: address-field typedefs, FSM state
// encoding and the byte-lane merge used by stores.
package l1_dcache_pkg;

    localparam int S_INDEX_DEFAULT = 3;
    localparam int OFFSET_W        = 4;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_datbus;
    typedef logic [S_INDEX_DEFAULT-1:0]                 lc3b_c_index;
    typedef logic [16-OFFSET_W-S_INDEX_DEFAULT-1:0]     lc3b_c_tag;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } l1_dcache_state_t;

    function automatic lc3b_datbus merge_bytes(input lc3b_datbus old_line,
                                               input lc3b_datbus new_line,
                                               input logic [15:0] byte_en);
        lc3b_datbus res;
        res = old_line;
        for (int i = 0; i < 16; i++) begin
            if (byte_en[i]) res[8*i +: 8] = new_line[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/l1_dcache_way.sv
// One way of the cache: data/tag arrays (not reset) plus valid/dirty bits
// (async cleared), with a combinational lookup at the presented index.
module l1_dcache_way
    import l1_dcache_pkg::*;
#(
    parameter int S_INDEX = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [S_INDEX-1:0]   i_index,
    input  logic [11-S_INDEX:0]  i_tag,
    input  logic                 i_load_line,
    input  logic [127:0]         i_line_in,
    input  logic                 i_store,
    input  logic [127:0]         i_wdata,
    input  logic [15:0]          i_byte_en,
    input  logic                 i_set_dirty,
    output logic [127:0]         o_line,
    output logic [11-S_INDEX:0]  o_tag,
    output logic                 o_valid,
    output logic                 o_dirty,
    output logic                 o_hit
);

    localparam int SETS = 1 << S_INDEX;

    logic [127:0]        r_data [SETS];
    logic [11-S_INDEX:0] r_tag  [SETS];
    logic [SETS-1:0]     r_valid;
    logic [SETS-1:0]     r_dirty;

    always_ff @(posedge clk) begin
        if (i_load_line) begin
            r_data[i_index] <= i_line_in;
            r_tag[i_index]  <= i_tag;
        end else if (i_store) begin
            r_data[i_index] <= merge_bytes(r_data[i_index], i_wdata, i_byte_en);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_load_line) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_set_dirty) begin
            r_dirty[i_index] <= 1'b1;
        end
    end

    assign o_line  = r_data[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_hit   = r_valid[i_index] && (r_tag[i_index] == i_tag);

endmodule

// File: rtl/l1_dcache.sv
// 2-way set-associative write-back/write-allocate L1 data cache with true LRU.
// Core side: req held until resp. Memory side: one line transfer per pmem_resp.
module l1_dcache
    import l1_dcache_pkg::*;
#(
    parameter int s_index = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         dcache_mem_req,
    input  logic         dcache_we_on_req,
    input  logic [15:0]  dcache_addr,
    input  logic [127:0] dcache_wdata,
    input  logic [15:0]  dcache_byte_en,
    output logic         dcache_resp,
    output logic [127:0] dcache_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_addr,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata,
    output logic [1:0]   o_dbg_state
);

    localparam int TAG_W = 12 - s_index;
    localparam int SETS  = 1 << s_index;

    l1_dcache_state_t r_state, w_next;
    logic [11:0]      r_line;
    logic [SETS-1:0]  r_lru;

    logic [s_index-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_victim;
    logic               w_hit_way;
    logic               w_lru_we;
    logic               w_lru_val;
    logic [1:0]         w_load, w_store, w_set_dirty;
    logic [1:0]         w_valid, w_dirty, w_hit;
    logic [127:0]       w_line    [2];
    logic [TAG_W-1:0]   w_way_tag [2];
    logic               w_unused;

    // Address is captured on acceptance so a requester that walks away
    // mid-miss cannot retarget the fill in flight.
    assign w_index   = r_line[s_index-1:0];
    assign w_tag     = r_line[11:s_index];
    assign w_victim  = r_lru[w_index];
    assign w_hit_way = w_hit[1];
    assign w_unused  = ^dcache_addr[3:0];
    assign o_dbg_state = r_state;

    for (genvar g = 0; g < 2; g++) begin : g_way
        l1_dcache_way #(.S_INDEX(s_index)) u_way (
            .clk         (clk),
            .rst         (reset),
            .i_index     (w_index),
            .i_tag       (w_tag),
            .i_load_line (w_load[g]),
            .i_line_in   (pmem_rdata),
            .i_store     (w_store[g]),
            .i_wdata     (dcache_wdata),
            .i_byte_en   (dcache_byte_en),
            .i_set_dirty (w_set_dirty[g]),
            .o_line      (w_line[g]),
            .o_tag       (w_way_tag[g]),
            .o_valid     (w_valid[g]),
            .o_dirty     (w_dirty[g]),
            .o_hit       (w_hit[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_lru   <= '0;
            r_line  <= '0;
        end else begin
            r_state <= w_next;
            if (w_lru_we) r_lru[w_index] <= w_lru_val;
            if (r_state == IDLE && dcache_mem_req) r_line <= dcache_addr[15:4];
        end
    end

    always_comb begin
        w_next       = r_state;
        dcache_resp  = 1'b0;
        dcache_rdata = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_addr    = '0;
        pmem_wdata   = '0;
        w_load       = '0;
        w_store      = '0;
        w_set_dirty  = '0;
        w_lru_we     = 1'b0;
        w_lru_val    = 1'b0;
        case (r_state)
            IDLE: begin
                if (dcache_mem_req) w_next = CHECK;
            end
            CHECK: begin
                if (!dcache_mem_req) begin
                    w_next = IDLE;
                end else if (|w_hit) begin
                    dcache_resp  = 1'b1;
                    dcache_rdata = w_line[w_hit_way];
                    w_lru_we     = 1'b1;
                    w_lru_val    = ~w_hit_way;
                    if (dcache_we_on_req) begin
                        w_store[w_hit_way]     = 1'b1;
                        w_set_dirty[w_hit_way] = |dcache_byte_en;
                    end
                    w_next = IDLE;
                end else if (w_valid[w_victim] && w_dirty[w_victim]) begin
                    w_next = WRITEBACK;
                end else begin
                    w_next = ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write = 1'b1;
                pmem_addr  = {w_way_tag[w_victim], w_index, 4'h0};
                pmem_wdata = w_line[w_victim];
                if (pmem_resp) w_next = ALLOCATE;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                pmem_addr = {w_tag, w_index, 4'h0};
                if (pmem_resp) begin
                    w_load[w_victim] = 1'b1;
                    w_next           = CHECK;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache: a transaction-level cache/memory model sets
// per-cycle expectations that a single negedge compare process checks.
module tb_l1_dcache;

    logic         clk = 1'b0;
    logic         reset;
    logic         dcache_mem_req;
    logic         dcache_we_on_req;
    logic [15:0]  dcache_addr;
    logic [127:0] dcache_wdata;
    logic [15:0]  dcache_byte_en;
    logic         dcache_resp;
    logic [127:0] dcache_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_addr;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic [1:0]   unused_dbg_state;

    l1_dcache dut (
        .clk              (clk),
        .reset            (reset),
        .dcache_mem_req   (dcache_mem_req),
        .dcache_we_on_req (dcache_we_on_req),
        .dcache_addr      (dcache_addr),
        .dcache_wdata     (dcache_wdata),
        .dcache_byte_en   (dcache_byte_en),
        .dcache_resp      (dcache_resp),
        .dcache_rdata     (dcache_rdata),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_addr        (pmem_addr),
        .pmem_wdata       (pmem_wdata),
        .pmem_resp        (pmem_resp),
        .pmem_rdata       (pmem_rdata),
        .o_dbg_state      (unused_dbg_state)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] L0  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] L0M = 128'h00112233_44556677_8899EFBE_CCDDEEFF;

    int n_vec = 0;
    int n_err = 0;

    // Expected outputs for the current cycle
    logic         chk_en = 1'b0;
    logic         exp_resp, chk_rdata, exp_read, exp_write;
    logic [127:0] exp_rdata, exp_wdata;
    logic [15:0]  exp_addr;

    logic [127:0] cap_rdata, cap_wb_data;
    logic [15:0]  cap_wb_addr;

    // Model: each set is an MRU slot and an LRU slot; misses replace the LRU slot
    typedef struct {
        bit           valid;
        logic [15:0]  addr;
        logic [127:0] data;
        bit           dirty;
    } slot_t;
    slot_t m_mru [8];
    slot_t m_lru [8];
    logic [127:0] mem [logic [15:0]];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("dcache_resp", {127'b0, dcache_resp}, {127'b0, exp_resp});
            if (exp_resp) begin
                if (chk_rdata) check("dcache_rdata", dcache_rdata, exp_rdata);
            end else begin
                check("dcache_rdata_idle", dcache_rdata, '0);
            end
            check("pmem_read",  {127'b0, pmem_read},  {127'b0, exp_read});
            check("pmem_write", {127'b0, pmem_write}, {127'b0, exp_write});
            check("pmem_addr",  {112'b0, pmem_addr},  {112'b0, exp_addr});
            check("pmem_wdata", pmem_wdata, exp_wdata);
            if (dcache_resp === 1'b1) cap_rdata = dcache_rdata;
            if (pmem_write === 1'b1) begin
                cap_wb_addr = pmem_addr;
                cap_wb_data = pmem_wdata;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        exp_resp  = 1'b0;
        chk_rdata = 1'b0;
        exp_rdata = '0;
        exp_read  = 1'b0;
        exp_write = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
    endtask

    function automatic logic [127:0] mem_get(input logic [15:0] la);
        if (mem.exists(la)) return mem[la];
        return {8{la}};
    endfunction

    function automatic logic [127:0] merge(input logic [127:0] old_l, input logic [127:0] nw,
                                           input logic [15:0] be);
        logic [127:0] r;
        r = old_l;
        for (int i = 0; i < 16; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_mru[i] = '{valid: 1'b0, addr: '0, data: '0, dirty: 1'b0};
            m_lru[i] = '{valid: 1'b0, addr: '0, data: '0, dirty: 1'b0};
        end
    endtask

    // mode: 0 = normal, 1 = drop request during fill, 2 = reset during fill
    task automatic access(input logic [15:0] a, input logic we, input logic [127:0] wd,
                          input logic [15:0] be, input int wb_lat, input int fill_lat,
                          input int mode);
        int           s;
        logic [15:0]  la;
        slot_t        v, t;
        bit           hit_m, hit_l;
        s  = int'(a[6:4]);
        la = {a[15:4], 4'h0};
        idle_exp();
        dcache_mem_req   = 1'b1;
        dcache_we_on_req = we;
        dcache_addr      = a;
        dcache_wdata     = wd;
        dcache_byte_en   = be;
        cyc();
        hit_m = m_mru[s].valid && m_mru[s].addr == la;
        hit_l = m_lru[s].valid && m_lru[s].addr == la;
        if (!hit_m && !hit_l) begin
            idle_exp();
            v = m_lru[s];
            if (v.valid && v.dirty) begin
                for (int k = 0; k < wb_lat; k++) begin
                    cyc();
                    idle_exp();
                    exp_write = 1'b1;
                    exp_addr  = v.addr;
                    exp_wdata = v.data;
                    pmem_resp = (k == wb_lat - 1);
                end
                mem[v.addr] = v.data;
            end
            for (int k = 0; k < fill_lat; k++) begin
                cyc();
                idle_exp();
                exp_read   = 1'b1;
                exp_addr   = la;
                pmem_resp  = (k == fill_lat - 1) && (mode != 2);
                pmem_rdata = mem_get(la);
                if (k == 0 && mode == 1) dcache_mem_req = 1'b0;
                if (k == 0 && mode == 2) begin
                    cyc();
                    reset          = 1'b1;
                    dcache_mem_req = 1'b0;
                    pmem_resp      = 1'b0;
                    idle_exp();
                    cyc();
                    reset = 1'b0;
                    model_clear();
                    return;
                end
            end
            cyc();
            pmem_resp = 1'b0;
            idle_exp();
            m_lru[s] = '{valid: 1'b1, addr: la, data: mem_get(la), dirty: 1'b0};
            hit_l = 1'b1;
            if (mode == 1) begin
                cyc();
                idle_exp();
                return;
            end
        end
        if (hit_l) begin
            t        = m_mru[s];
            m_mru[s] = m_lru[s];
            m_lru[s] = t;
        end
        exp_resp = 1'b1;
        if (!we) begin
            chk_rdata = 1'b1;
            exp_rdata = m_mru[s].data;
        end else begin
            m_mru[s].data = merge(m_mru[s].data, wd, be);
            if (be != 16'h0) m_mru[s].dirty = 1'b1;
        end
        cyc();
        dcache_mem_req = 1'b0;
        idle_exp();
    endtask

    initial begin
        reset            = 1'b1;
        dcache_mem_req   = 1'b0;
        dcache_we_on_req = 1'b0;
        dcache_addr      = '0;
        dcache_wdata     = '0;
        dcache_byte_en   = '0;
        pmem_resp        = 1'b0;
        pmem_rdata       = '0;
        cap_rdata        = '0;
        cap_wb_addr      = '0;
        cap_wb_data      = '0;
        model_clear();
        mem[16'h1230] = L0;
        idle_exp();
        chk_en = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();

        // Cold miss fill, then hits on the same line
        access(16'h1236, 1'b0, '0, 16'h0, 1, 2, 0);
        check("pin_fill_L0", cap_rdata, L0);
        access(16'h123A, 1'b0, '0, 16'h0, 1, 1, 0);
        check("pin_hit_L0", cap_rdata, L0);

        // Byte-lane store then reload
        access(16'h1234, 1'b1, 128'h0000EFBE_00000000, 16'h0030, 1, 1, 0);
        access(16'h1234, 1'b0, '0, 16'h0, 1, 1, 0);
        check("pin_merged", cap_rdata, L0M);

        // Fill the other way, then evict the dirty LRU line
        access(16'h2230, 1'b0, '0, 16'h0, 1, 1, 0);
        access(16'h3230, 1'b0, '0, 16'h0, 2, 3, 0);
        check("pin_wb_addr", {112'b0, cap_wb_addr}, {112'b0, 16'h1230});
        check("pin_wb_data", cap_wb_data, L0M);

        // Reset while a fill is pending; everything misses afterwards
        access(16'h4450, 1'b0, '0, 16'h0, 1, 3, 2);
        access(16'h1230, 1'b0, '0, 16'h0, 1, 2, 0);
        check("pin_refill", cap_rdata, L0M);

        // Stray pmem_resp in IDLE is ignored
        idle_exp();
        pmem_resp = 1'b1;
        cyc();
        pmem_resp = 1'b0;
        cyc();
        access(16'h1230, 1'b0, '0, 16'h0, 1, 1, 0);

        // Abandoned miss completes the fill, then hits
        access(16'h5678, 1'b0, '0, 16'h0, 1, 2, 1);
        access(16'h5670, 1'b0, '0, 16'h0, 1, 1, 0);
        check("pin_abandoned", cap_rdata, {8{16'h5670}});

        // Zero byte-enable store leaves the line clean: eviction has no writeback
        access(16'h5670, 1'b1, {8{16'hFFFF}}, 16'h0000, 1, 1, 0);
        access(16'h6670, 1'b1, {8{16'hA5A5}}, 16'hFFFF, 1, 1, 0);
        access(16'h7670, 1'b0, '0, 16'h0, 1, 2, 0);
        access(16'h5670, 1'b0, '0, 16'h0, 3, 1, 0);
        check("pin_full_store_wb", cap_wb_data, {8{16'hA5A5}});

        // Back-to-back hits
        access(16'h5674, 1'b0, '0, 16'h0, 1, 1, 0);
        access(16'h7670, 1'b0, '0, 16'h0, 1, 1, 0);
        cyc();
        cyc();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
